ripple_count_ctrl: RTL and testbench
====================================

# ripple_count_ctrl

Controller that sequences an external asynchronous ripple up-counter (T-flip-flop chain) as an event counter. It clears the counter, gates the event stream into it, synchronises and debounces the counter's asynchronous outputs into the `clk` domain, and stops the run when a programmed target is reached. It supports one-shot and periodic modes. It sits between the ripple counter and the synchronous control logic, and is the only driver of the counter's reset and event gate.

## Interface
- `WIDTH`, default 4: counter width in bits.
- `SETTLE`, default 2: consecutive identical synchronised samples required before a counter value is accepted (≥1).
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `start`  in  1: single-cycle run request; ignored while `busy`=1.
- `abort`  in  1: terminate the current run; has priority over all other events.
- `mode`  in  1: 0 = one-shot, 1 = periodic. Sampled on accepted `start`.
- `target`  in  WIDTH: terminal count. Sampled on accepted `start`.
- `cnt_q`  in  WIDTH: ripple counter outputs. Asynchronous to `clk`.
- `cnt_clr`  out  1: drives the counter's active-high reset.
- `cnt_en`  out  1: gates the event stream into the counter's clock input.
- `busy`  out  1: a run is in progress.
- `done`  out  1: one-cycle pulse per completed count period.
- `over`  out  1: the completed period overshot or wrapped. Valid with `done`, held until the next `done` or `start`.
- `count_out`  out  WIDTH: last accepted stable counter value.

## Operation
- States: IDLE, CLEAR, RUN, STOP.
- **IDLE:** `cnt_clr`=1, `cnt_en`=0, `busy`=0.
  - `start` with `target`=0: `done` pulses next cycle with `over`=0, and the state stays IDLE.
  - `start` with `target`≠0: latch `mode` and `target`, then go to CLEAR.
- **CLEAR:** `cnt_clr`=1, `cnt_en`=0 for exactly CLR_CYCLES=2 cycles, then go to RUN. The stability filter is flushed to 0.
- **RUN:** `cnt_clr`=0, `cnt_en`=1.
  - `cnt_q` passes through a 2-flop synchroniser.
  - A value is accepted when the synchroniser output has been unchanged for SETTLE consecutive cycles. The accepted value updates `count_out`.
  - Accepted value == `target`: go to STOP with `over`=0.
  - Accepted value > `target`: go to STOP with `over`=1.
  - Accepted value < previous accepted value (wrap past all-ones): go to STOP with `over`=1.
- **STOP:** `cnt_en`=0 and `done` pulses for one cycle.
  - `mode`=0: go to IDLE.
  - `mode`=1: go to CLEAR and restart the period with the same latched `target`.
- **Abort:** `abort` in CLEAR, RUN or STOP forces IDLE on the next edge with no `done` pulse. `over` and `count_out` keep their values. If `abort` and a `done`-producing condition occur in the same cycle, `abort` wins.
- Comparisons are unsigned, WIDTH bits.
- Reset mid-run returns every output to its reset value immediately (asynchronously). The counter is cleared because `cnt_clr`=1.

## Timing
- Reset values: `cnt_clr`=1, `cnt_en`=0, `busy`=0, `done`=0, `over`=0, `count_out`=0. The state is IDLE.
- `start` accepted at edge N:
  - `busy`=1 from N+1.
  - `cnt_clr`=1 for N+1..N+2.
  - `cnt_en`=1 from N+3.
- Acceptance latency: a counter value that settles before edge M is accepted at edge M+1+SETTLE (2 synchroniser flops, then SETTLE stable cycles).
- `done` asserts on the edge after acceptance. `busy` drops together with `done` in one-shot mode.
- Periodic restart: `cnt_en` is low for 3 cycles between periods (STOP + 2×CLEAR).
- The event stream is assumed slower than 2+SETTLE `clk` cycles per event. Faster streams are reported via `over`, not blocked.

## Structure
- Shared package `ripple_count_pkg`: state enum (IDLE, CLEAR, RUN, STOP) and constant CLR_CYCLES=2.
- Sub-module `cnt_sync_stable`:
  - Parameters WIDTH and SETTLE.
  - Inputs: async bus, `flush`.
  - Outputs: `stable_val`, `stable_vld` (one-cycle pulse on each newly accepted value).
  - Contains the synchroniser and the stability counter.
- The top level holds the FSM, the target/mode latches, the comparator and the wrap detector.

## Test plan
- Reset mid-RUN with `cnt_q`=5 → all outputs return to reset values immediately; `cnt_clr`=1.
- One-shot, `target`=4; model `cnt_q` steps 0→1→2→3→4 every 10 cycles → exactly one `done` with `count_out`=4, `over`=0; `cnt_en` falls with `done`; `busy` then returns to 0.
- Periodic, `target`=3 → `done` every period; `cnt_clr` high for 2 cycles after each `done`; `start` pulses during `busy` have no effect.
- Overshoot: `target`=6; `cnt_q` jumps 5→7 within one cycle → `done` with `count_out`=7, `over`=1. Wrap: `target`=15; `cnt_q` 14→0 → `done` with `over`=1.
- `abort` issued in the same cycle as a match on `target`=2 → IDLE, no `done`, `cnt_en`=0 next cycle.
- `start` with `target`=0 → `done` one cycle later; `busy` stays 0 and `cnt_en` never asserts.

Source files
------------

// File: rtl/ripple_count_ctrl_pkg.sv
// Shared types and constants for the ripple-counter controller.
package ripple_count_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int unsigned CLR_CYCLES = 2;

endpackage

// File: rtl/ripple_count_ctrl_if.sv
// Control/status bundle between the ripple-counter controller and its users.
interface ripple_count_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             abort;
  logic             mode;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_clr;
  logic             cnt_en;
  logic             busy;
  logic             done;
  logic             over;
  logic [WIDTH-1:0] count_out;

  modport slave (
    input  start, abort, mode, target, cnt_q,
    output cnt_clr, cnt_en, busy, done, over, count_out
  );

  modport master (
    output start, abort, mode, target, cnt_q,
    input  cnt_clr, cnt_en, busy, done, over, count_out
  );
endinterface

// File: rtl/ripple_count_ctrl_cnt_sync_stable.sv
// Two-flop synchroniser for the asynchronous counter bus plus a stability filter
// that accepts a value once it has been unchanged for SETTLE cycles.
module cnt_sync_stable #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] stable_val_o,
  output logic             stable_vld_o
);

  localparam int unsigned     HW        = $clog2(SETTLE + 1);
  localparam logic [HW-1:0]   SETTLE_W  = HW'(SETTLE);
  localparam logic [HW-1:0]   ACCEPT_AT = HW'(SETTLE - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q, stable_val_q;
  logic [HW-1:0]    hold_q, hold_d, held_s;
  logic             accept_s, stable_vld_q;

  // held_s counts cycles sync2_q has shown its value, including the current one
  always_comb begin
    if (hold_q == SETTLE_W) begin
      held_s = hold_q;
    end else begin
      held_s = hold_q + HW'(1);
    end
    accept_s = (hold_q == ACCEPT_AT);
    if (sync1_q != sync2_q) begin
      hold_d = {HW{1'b0}};
    end else begin
      hold_d = held_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= {WIDTH{1'b0}};
      sync2_q      <= {WIDTH{1'b0}};
      hold_q       <= {HW{1'b0}};
      stable_val_q <= {WIDTH{1'b0}};
      stable_vld_q <= 1'b0;
    end else if (flush_i) begin
      sync1_q      <= {WIDTH{1'b0}};
      sync2_q      <= {WIDTH{1'b0}};
      hold_q       <= {HW{1'b0}};
      stable_val_q <= {WIDTH{1'b0}};
      stable_vld_q <= 1'b0;
    end else begin
      sync1_q      <= async_i;
      sync2_q      <= sync1_q;
      hold_q       <= hold_d;
      stable_vld_q <= accept_s;
      if (accept_s) begin
        stable_val_q <= sync2_q;
      end
    end
  end

  assign stable_val_o = stable_val_q;
  assign stable_vld_o = stable_vld_q;

endmodule

// File: rtl/ripple_count_ctrl.sv
// Sequences an external ripple up-counter: clear, gate events, filter its outputs
// and stop (one-shot or periodic) when the latched target is reached or passed.
module ripple_count_ctrl
  import ripple_count_pkg::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  ripple_count_ctrl_if.slave ctrl_if
);

  localparam logic [1:0] CLR_LAST = 2'(CLR_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       clr_cnt_q, clr_cnt_d;
  logic             mode_q;
  logic [WIDTH-1:0] target_q, prev_q, count_out_q;
  logic             over_q, cnt_clr_q, cnt_en_q, busy_q, done_q;
  logic             cnt_clr_d, cnt_en_d, busy_d, done_d;
  logic [WIDTH-1:0] stable_val_s;
  logic             stable_vld_s, start_acc_s, zero_start_s, hit_s, over_s, flush_s;

  assign flush_s = (state_q == CLEAR);

  cnt_sync_stable #(.WIDTH(WIDTH), .SETTLE(SETTLE)) u_sync (
    .clk          (clk),
    .rst          (rst),
    .async_i      (ctrl_if.cnt_q),
    .flush_i      (flush_s),
    .stable_val_o (stable_val_s),
    .stable_vld_o (stable_vld_s)
  );

  // A value below the previous accepted one means the counter wrapped
  always_comb begin
    start_acc_s  = (state_q == IDLE) && ctrl_if.start && !ctrl_if.abort;
    zero_start_s = start_acc_s && (ctrl_if.target == {WIDTH{1'b0}});
    over_s       = (stable_val_s > target_q) || (stable_val_s < prev_q);
    hit_s        = stable_vld_s && ((stable_val_s == target_q) || over_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clr_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_acc_s && !zero_start_s) begin
          state_d   = CLEAR;
          clr_cnt_d = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (ctrl_if.abort) begin
          state_d = IDLE;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d = RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 2'd1;
        end
      end
      RUN: begin
        if (ctrl_if.abort) begin
          state_d = IDLE;
        end else if (hit_s) begin
          state_d = STOP;
        end else begin
          state_d = RUN;
        end
      end
      STOP: begin
        if (ctrl_if.abort) begin
          state_d = IDLE;
        end else if (mode_q) begin
          state_d   = CLEAR;
          clr_cnt_d = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned with it
  always_comb begin
    cnt_clr_d = (state_d == IDLE) || (state_d == CLEAR);
    cnt_en_d  = (state_d == RUN);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == STOP) || zero_start_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_clr_q   <= 1'b1;
      cnt_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      over_q      <= 1'b0;
      count_out_q <= {WIDTH{1'b0}};
      prev_q      <= {WIDTH{1'b0}};
      target_q    <= {WIDTH{1'b0}};
      mode_q      <= 1'b0;
    end else begin
      cnt_clr_q <= cnt_clr_d;
      cnt_en_q  <= cnt_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (start_acc_s) begin
        mode_q   <= ctrl_if.mode;
        target_q <= ctrl_if.target;
        over_q   <= 1'b0;
      end else if (flush_s) begin
        prev_q <= {WIDTH{1'b0}};
      end else if ((state_q == RUN) && !ctrl_if.abort && stable_vld_s) begin
        count_out_q <= stable_val_s;
        prev_q      <= stable_val_s;
        if (hit_s) begin
          over_q <= over_s;
        end
      end
    end
  end

  assign ctrl_if.cnt_clr   = cnt_clr_q;
  assign ctrl_if.cnt_en    = cnt_en_q;
  assign ctrl_if.busy      = busy_q;
  assign ctrl_if.done      = done_q;
  assign ctrl_if.over      = over_q;
  assign ctrl_if.count_out = count_out_q;

endmodule

// File: tb/tb_ripple_count_ctrl.sv
// Directed and randomised bench for ripple_count_ctrl; the ripple counter is a
// value the bench drives, and run outcomes come from a list-scanning reference.
module tb_ripple_count_ctrl;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned SETTLE = 2;
  localparam int          LAT    = 3 + SETTLE;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] cnt_model;
  bit         m_over;
  logic [3:0] seq_v [$];
  logic [3:0] r_tgt, r_v, r_pv;

  ripple_count_ctrl_if #(.WIDTH(WIDTH)) bus ();

  ripple_count_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample just after the edge; a cleared counter reads zero
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.cnt_clr === 1'b1) cnt_model = 4'd0;
    bus.cnt_q = cnt_model;
  endtask

  task automatic drive_cnt(input logic [3:0] v);
    cnt_model = v;
    bus.cnt_q = v;
  endtask

  task automatic start_run(input logic [3:0] tgt, input bit md, input string tag);
    bus.start = 1'b1; bus.target = tgt; bus.mode = md;
    tick();
    bus.start = 1'b0;
    m_over = 1'b0;
    chk({tag, " busy after start"}, 32'(bus.busy), 32'd1);
    chk({tag, " clr cycle1"}, 32'(bus.cnt_clr), 32'd1);
    chk({tag, " en low cycle1"}, 32'(bus.cnt_en), 32'd0);
    chk({tag, " over cleared"}, 32'(bus.over), 32'd0);
    tick();
    chk({tag, " clr cycle2"}, 32'(bus.cnt_clr), 32'd1);
    chk({tag, " en low cycle2"}, 32'(bus.cnt_en), 32'd0);
    tick();
    chk({tag, " en high"}, 32'(bus.cnt_en), 32'd1);
    chk({tag, " clr low"}, 32'(bus.cnt_clr), 32'd0);
  endtask

  // Feed seq_v until the reference says the period ends, then check the ending
  task automatic run_period(input logic [3:0] tgt, input bit periodic, input bit do_abort,
                            input string tag);
    int end_i = -1;
    int gap;
    int waited = 0;
    logic [3:0] prev = 4'd0;
    logic [3:0] exp_val = 4'd0;
    bit exp_ov = 1'b0;
    for (int i = 0; i < seq_v.size(); i++) begin
      if (end_i < 0) begin
        if ((seq_v[i] >= tgt) || (seq_v[i] < prev)) begin
          end_i   = i;
          exp_val = seq_v[i];
          exp_ov  = (seq_v[i] > tgt) || (seq_v[i] < prev);
        end else begin
          prev = seq_v[i];
        end
      end
    end
    while ((bus.cnt_en !== 1'b1) && (waited < 10)) begin
      tick();
      waited++;
    end
    for (int i = 0; i <= end_i; i++) begin
      chk({tag, " en before event"}, 32'(bus.cnt_en), 32'd1);
      drive_cnt(seq_v[i]);
      gap = (i == end_i) ? LAT : int'($urandom_range(12, 7));
      for (int g = 1; g <= gap; g++) begin
        tick();
        if (!((i == end_i) && (g == gap))) chk({tag, " no early done"}, 32'(bus.done), 32'd0);
        if (do_abort && (i == end_i) && (g == LAT - 1)) bus.abort = 1'b1;
        if (periodic) begin
          bus.start  = (g == 2);
          bus.target = 4'd1;
        end
      end
    end
    if (do_abort) begin
      bus.abort = 1'b0;
      chk({tag, " no done"}, 32'(bus.done), 32'd0);
      chk({tag, " busy low"}, 32'(bus.busy), 32'd0);
      chk({tag, " en low"}, 32'(bus.cnt_en), 32'd0);
      chk({tag, " clr high"}, 32'(bus.cnt_clr), 32'd1);
      chk({tag, " count kept"}, 32'(bus.count_out), 32'(prev));
      chk({tag, " over kept"}, 32'(bus.over), 32'(m_over));
    end else begin
      chk({tag, " done"}, 32'(bus.done), 32'd1);
      chk({tag, " count_out"}, 32'(bus.count_out), 32'(exp_val));
      chk({tag, " over"}, 32'(bus.over), 32'(exp_ov));
      chk({tag, " en falls with done"}, 32'(bus.cnt_en), 32'd0);
      chk({tag, " clr low in stop"}, 32'(bus.cnt_clr), 32'd0);
      chk({tag, " busy with done"}, 32'(bus.busy), 32'd1);
      m_over = exp_ov;
      tick();
      chk({tag, " single done"}, 32'(bus.done), 32'd0);
      chk({tag, " over held"}, 32'(bus.over), 32'(m_over));
      if (periodic) begin
        chk({tag, " restart clr1"}, 32'(bus.cnt_clr), 32'd1);
        chk({tag, " restart en1"}, 32'(bus.cnt_en), 32'd0);
        chk({tag, " restart busy"}, 32'(bus.busy), 32'd1);
        tick();
        chk({tag, " restart clr2"}, 32'(bus.cnt_clr), 32'd1);
        chk({tag, " restart en2"}, 32'(bus.cnt_en), 32'd0);
        tick();
        chk({tag, " restart en"}, 32'(bus.cnt_en), 32'd1);
        chk({tag, " restart clr low"}, 32'(bus.cnt_clr), 32'd0);
      end else begin
        chk({tag, " busy drops"}, 32'(bus.busy), 32'd0);
        chk({tag, " idle clr"}, 32'(bus.cnt_clr), 32'd1);
        chk({tag, " idle en"}, 32'(bus.cnt_en), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0;
    bus.target = 4'd0; bus.cnt_q = 4'd0;
    cnt_model = 4'd0; m_over = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset cnt_clr", 32'(bus.cnt_clr), 32'd1);
    chk("reset cnt_en", 32'(bus.cnt_en), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset over", 32'(bus.over), 32'd0);
    chk("reset count_out", 32'(bus.count_out), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // zero target: done next cycle, never busy, never enabled
    bus.start = 1'b1; bus.target = 4'd0; bus.mode = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("zero done", 32'(bus.done), 32'd1);
    chk("zero over", 32'(bus.over), 32'd0);
    chk("zero busy", 32'(bus.busy), 32'd0);
    chk("zero en", 32'(bus.cnt_en), 32'd0);
    tick();
    chk("zero done once", 32'(bus.done), 32'd0);
    chk("zero busy after", 32'(bus.busy), 32'd0);
    chk("zero en after", 32'(bus.cnt_en), 32'd0);

    seq_v = '{4'd1, 4'd2, 4'd3, 4'd4};
    start_run(4'd4, 1'b0, "oneshot");
    run_period(4'd4, 1'b0, 1'b0, "oneshot");

    seq_v = '{4'd1, 4'd2, 4'd3};
    start_run(4'd3, 1'b1, "periodic");
    for (int p = 0; p < 3; p++) run_period(4'd3, 1'b1, 1'b0, "periodic");
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("periodic abort busy", 32'(bus.busy), 32'd0);
    chk("periodic abort en", 32'(bus.cnt_en), 32'd0);
    chk("periodic abort done", 32'(bus.done), 32'd0);

    seq_v = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7};
    start_run(4'd6, 1'b0, "overshoot");
    run_period(4'd6, 1'b0, 1'b0, "overshoot");

    seq_v = '{4'd3, 4'd7, 4'd11, 4'd14, 4'd0};
    start_run(4'd15, 1'b0, "wrap");
    run_period(4'd15, 1'b0, 1'b0, "wrap");

    seq_v = '{4'd1, 4'd2};
    start_run(4'd2, 1'b0, "abort");
    run_period(4'd2, 1'b0, 1'b1, "abort");
    tick();
    chk("abort no late done", 32'(bus.done), 32'd0);

    for (int r = 0; r < 4; r++) begin
      r_tgt = 4'($urandom_range(15, 1));
      seq_v.delete();
      r_v = 4'd0; r_pv = 4'd0;
      for (int k = 0; k < 40; k++) begin
        r_v = r_v + (($urandom_range(4, 0) == 0) ? 4'd2 : 4'd1);
        seq_v.push_back(r_v);
        if ((r_v >= r_tgt) || (r_v < r_pv)) break;
        r_pv = r_v;
      end
      start_run(r_tgt, 1'b0, "random");
      run_period(r_tgt, 1'b0, 1'b0, "random");
    end

    // reset in the middle of a run with the counter at 5
    start_run(4'd9, 1'b0, "rstrun");
    drive_cnt(4'd5);
    repeat (6) tick();
    chk("rstrun count_out before", 32'(bus.count_out), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("rstrun cnt_clr", 32'(bus.cnt_clr), 32'd1);
    chk("rstrun cnt_en", 32'(bus.cnt_en), 32'd0);
    chk("rstrun busy", 32'(bus.busy), 32'd0);
    chk("rstrun done", 32'(bus.done), 32'd0);
    chk("rstrun over", 32'(bus.over), 32'd0);
    chk("rstrun count_out", 32'(bus.count_out), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
